// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults and parameter legality check for the wrapping counter.
package counter_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CLOCKS_PER_INCREMENT = 1;
    localparam int DEF_MIN_VALUE = 0;
    localparam int DEF_MAX_VALUE = 5;

    // Wide counters (>=31 bits) can hold any non-negative int MAX_VALUE.
    function automatic bit params_ok(int width, int cpi, int min_value, int max_value);
        return width >= 1 && cpi >= 1 && min_value <= max_value &&
               (width >= 31 || max_value < (1 << width));
    endfunction
endpackage

// File: rtl/counter_if.sv
// counter_if: carries the counter reset and count value between producer and observers.
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic clk
);
    logic rst;
    logic [WIDTH-1:0] count;

    modport master (input clk, input rst, output count);
    modport slave (input clk, input rst, input count);
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides clk into a one-cycle tick every CLOCKS_PER_INCREMENT edges.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int CLOCKS_PER_INCREMENT = DEF_CLOCKS_PER_INCREMENT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PW = CLOCKS_PER_INCREMENT > 1 ? $clog2(CLOCKS_PER_INCREMENT) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLOCKS_PER_INCREMENT - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst)
        if (!rst) phase <= '0;
        else phase <= (phase == LAST) ? '0 : phase + 1'b1;

    assign tick = phase == LAST;
endmodule

// File: rtl/counter.sv
// counter: tick-gated count register stepping MIN_VALUE..MAX_VALUE and wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CLOCKS_PER_INCREMENT = DEF_CLOCKS_PER_INCREMENT,
    parameter int MIN_VALUE = DEF_MIN_VALUE,
    parameter int MAX_VALUE = DEF_MAX_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] SPAN = WIDTH'(MAX_VALUE - MIN_VALUE);

    if (!params_ok(WIDTH, CLOCKS_PER_INCREMENT, MIN_VALUE, MAX_VALUE)) begin : g_bad_params
        $fatal(1, "counter: illegal parameters WIDTH=%0d CPI=%0d MIN=%0d MAX=%0d",
               WIDTH, CLOCKS_PER_INCREMENT, MIN_VALUE, MAX_VALUE);
    end

    logic tick;

    counter_prescaler #(.CLOCKS_PER_INCREMENT(CLOCKS_PER_INCREMENT)) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Offset from LO wraps modulo 2^WIDTH, so values below LO also fail the range test and reload LO.
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= LO;
        else if (tick) count <= (count - LO < SPAN) ? count + 1'b1 : LO;
endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized reset stimulus on four counter configurations, scoreboard-checked.
module tb_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int q[4][$];
    int cpi[4] = '{1, 3, 1, 1};
    int mn[4] = '{0, 2, 7, 0};
    int mx[4] = '{5, 4, 7, 15};

    always #5 clk = ~clk;

    counter_if #(.WIDTH(8)) b0 (.clk(clk));
    counter_if #(.WIDTH(8)) b1 (.clk(clk));
    counter_if #(.WIDTH(8)) b2 (.clk(clk));
    counter_if #(.WIDTH(4)) b3 (.clk(clk));

    assign b0.rst = rst_n;
    assign b1.rst = rst_n;
    assign b2.rst = rst_n;
    assign b3.rst = rst_n;

    counter d0 (.clk(clk), .rst(b0.rst), .count(b0.count));
    counter #(.CLOCKS_PER_INCREMENT(3), .MIN_VALUE(2), .MAX_VALUE(4)) d1 (
        .clk(clk), .rst(b1.rst), .count(b1.count));
    counter #(.MIN_VALUE(7), .MAX_VALUE(7)) d2 (.clk(clk), .rst(b2.rst), .count(b2.count));
    counter #(.WIDTH(4), .MIN_VALUE(0), .MAX_VALUE(15)) d3 (
        .clk(clk), .rst(b3.rst), .count(b3.count));

    // Reference: value after n rising edges since reset release.
    function automatic int model(int i, int n);
        return mn[i] + (n / cpi[i]) % (mx[i] - mn[i] + 1);
    endfunction

    function automatic int cur(int i);
        case (i)
            0: return int'(b0.count);
            1: return int'(b1.count);
            2: return int'(b2.count);
            default: return int'(b3.count);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: count=%0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        edges = rst_n ? edges + 1 : 0;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) q[i].delete();
            q[i].push_back(model(i, edges));
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (q[i].size() > 0) chk($sformatf("seq%0d", i), cur(i), q[i].pop_front());
    end

    initial begin
        #12 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", cur(0), 0);
        chk("async_rst1", cur(1), 2);
        #10 rst_n = 1'b1;
        repeat (20) begin
            #($urandom_range(60, 120));
            @(posedge clk);
            #3 rst_n = 1'b0;
            #10;
            for (int i = 0; i < 4; i++) chk($sformatf("pulse%0d", i), cur(i), mn[i]);
            rst_n = 1'b1;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, the bit width of count.
REQ-002 The block SHALL take parameter CLOCKS_PER_INCREMENT, default 1, the number of clk rising edges per count step.
REQ-003 The block SHALL take parameter MIN_VALUE, default 0, the reset value and wrap target.
REQ-004 The block SHALL take parameter MAX_VALUE, default 5, the last value before wrap.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port count, output, WIDTH bits: the registered counter value.

Function
REQ-009 A prescaler SHALL count clk edges from 0 to CLOCKS_PER_INCREMENT-1, assert a one-cycle tick on the last value, then return to 0.
REQ-010 On each clk rising edge with tick high, count SHALL go to count+1 if count < MAX_VALUE, otherwise to MIN_VALUE (wrap).
REQ-011 With tick low, count SHALL hold its value.
REQ-012 After reset release, the first increment SHALL occur on the CLOCKS_PER_INCREMENT-th rising edge of clk.
REQ-013 The full sequence period SHALL be (MAX_VALUE-MIN_VALUE+1)*CLOCKS_PER_INCREMENT clk cycles.
REQ-014 With CLOCKS_PER_INCREMENT=1, tick SHALL be constantly high and count SHALL step every cycle.
REQ-015 With MIN_VALUE==MAX_VALUE, count SHALL stay at MIN_VALUE permanently.
REQ-016 If count holds a value outside [MIN_VALUE, MAX_VALUE], the next tick SHALL load MIN_VALUE.
REQ-017 count SHALL be driven directly from a flop, with no combinational path from any input.
REQ-018 Elaboration SHALL fail with a fatal message unless all of the following hold: WIDTH>=1, CLOCKS_PER_INCREMENT>=1, MIN_VALUE<=MAX_VALUE, and MAX_VALUE<=2^WIDTH-1.
REQ-019 The prescaler width SHALL be max(1, $clog2(CLOCKS_PER_INCREMENT)).

Reset
REQ-020 When rst is low, count SHALL take MIN_VALUE and the prescaler SHALL take 0 immediately, independent of clk.
REQ-021 While rst is low, all state SHALL hold its reset value.
REQ-022 Reset asserted mid-sequence (any count or prescaler phase) SHALL restart the sequence from MIN_VALUE with a full prescaler interval.
REQ-023 Counting SHALL resume on the clk edges following rst deassertion per REQ-012.

Structure
REQ-024 A package counter_pkg SHALL hold the parameter-legality check function and the shared defaults (WIDTH 8, CLOCKS_PER_INCREMENT 1, MIN_VALUE 0, MAX_VALUE 5).
REQ-025 The prescaler SHALL be the sub-module counter_prescaler: parameter CLOCKS_PER_INCREMENT; ports clk, rst, and output tick.
REQ-026 The top SHALL contain only the tick-gated count register and the wrap logic.

Verification
REQ-027 Defaults: release rst, then 12 clk edges -> count reads 1,2,3,4,5,0,1,2,3,4,5,0.
REQ-028 Defaults: pull rst low asynchronously mid-cycle while count=3 -> count=0 immediately, before the next clk edge.
REQ-029 Random reset pulses every 60-120 ns, each 10 ns low, 10 ns clock period -> count==MIN_VALUE at the end of every pulse.
REQ-030 CLOCKS_PER_INCREMENT=3, MIN_VALUE=2, MAX_VALUE=4 -> count holds each value 3 cycles, sequence 2,3,4,2, period 9 cycles.
REQ-031 MIN_VALUE=MAX_VALUE=7 -> count constantly 7 across 20 cycles.
REQ-032 WIDTH=4, MIN_VALUE=0, MAX_VALUE=15 -> count wraps 15->0 with no out-of-range value.
